// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Optional feature macro: PISO_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bits per frame: data bits plus optional parity bit.
    function automatic int FRAME_LEN(input int width, input int parity);
        return width + parity;
    endfunction

    // Width of a counter that spans 0..frame-1 (at least one bit).
    function automatic int CNT_W(input int frame);
        return (frame < 2) ? 1 : $clog2(frame);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-FRAME bit counter. Counts the bit position inside the frame being
// shifted; wraps to zero after FRAME-1 so a reload starts the next frame at 0.
module piso_bit_counter #(
    parameter int FRAME = 8,
    parameter int CW    = 3
) (
    input  logic clock,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [CW-1:0] r_count;

    // Position counter: clear dominates, otherwise step and wrap at LAST.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage feeding the downstream siso shift line.
// A one-word holding register lets consecutive words stream with no idle bit.
// Optional feature macro: PISO_PARITY_EN (even parity bit after the data bits).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy
);

    localparam int FRAME = FRAME_LEN(WIDTH, PARITY_BITS);
    localparam int CW    = CNT_W(FRAME);

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [FRAME-1:0] r_shift;

    logic             w_accept;
    logic             w_tc;
    logic             w_load;
    logic [FRAME-1:0] w_frame;
    logic [FRAME-1:0] w_shifted;
    logic             w_out_bit;

    // din_ready depends only on the hold flag, so there is no path from din_valid.
    assign w_accept = din_valid && !r_hold_full;

    // Hold moves into the shifter when starting from IDLE or at the end of a frame.
    assign w_load = r_hold_full && ((r_state == IDLE) || w_tc);

    // Frame image as loaded into the shifter; the first bit sits at the output end.
    generate
`ifdef PISO_PARITY_EN
        logic w_par;
        assign w_par = ^r_hold;
        if (MSB_FIRST) begin : g_frame_msb
            assign w_frame = {r_hold, w_par};
        end else begin : g_frame_lsb
            assign w_frame = {w_par, r_hold};
        end
`else
        assign w_frame = r_hold;
`endif
        if (MSB_FIRST) begin : g_dir_msb
            assign w_shifted = {r_shift[FRAME-2:0], 1'b0};
            assign w_out_bit = r_shift[FRAME-1];
        end else begin : g_dir_lsb
            assign w_shifted = {1'b0, r_shift[FRAME-1:1]};
            assign w_out_bit = r_shift[0];
        end
    endgenerate

    piso_bit_counter #(
        .FRAME (FRAME),
        .CW    (CW)
    ) u_cnt (
        .clock (clock),
        .rst   (rst),
        .i_clr (r_state == IDLE),
        .i_en  (r_state == SHIFT),
        .o_tc  (w_tc)
    );

    // Holding register: accept a word when empty, free it on the load edge.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Frame FSM and shifter: load, shift one bit per clock, reload or go idle at terminal count.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        r_shift <= w_frame;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tc) begin
                        if (r_hold_full) begin
                            r_shift <= w_frame;
                        end else begin
                            r_shift <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_shift <= w_shifted;
                    end
                end
                default: begin
                    r_shift <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign din_ready = !r_hold_full;
    assign so_valid  = (r_state == SHIFT);
    assign so        = (r_state == SHIFT) && w_out_bit;
    assign busy      = (r_state == SHIFT) || r_hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance.
// Build with PISO_PARITY_EN defined to exercise the parity frame.
module tb_piso_serializer;

    logic       clock = 1'b0;
    logic       rst   = 1'b0;

    logic [7:0] din_m = '0;
    logic       dv_m  = 1'b0;
    logic       rdy_m, so_m, sv_m, busy_m;

    logic [7:0] din_l = '0;
    logic       dv_l  = 1'b0;
    logic       rdy_l, so_l, sv_l, busy_l;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .rst(rst), .din(din_m), .din_valid(dv_m),
        .din_ready(rdy_m), .so(so_m), .so_valid(sv_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .rst(rst), .din(din_l), .din_valid(dv_l),
        .din_ready(rdy_l), .so(so_l), .so_valid(sv_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Offer a word to the MSB instance at a falling edge; returns #1 after the accept edge.
    task automatic offer_m(input logic [7:0] w);
        @(negedge clock);
        din_m = w;
        dv_m  = 1'b1;
        for (int i = 0; i < 40 && !rdy_m; i++) @(negedge clock);
        chk("offer_ready", {31'd0, rdy_m}, 32'd1);
        @(posedge clock);
        #1;
        dv_m = 1'b0;
    endtask

    // Starting #1 after an edge, wait briefly for so_valid, then gather bits (first bit ends up MSB).
    task automatic collect(input bit lsb, output logic [31:0] bits, output logic [31:0] rdy, output int n);
        bits = '0;
        rdy  = '0;
        n    = 0;
        for (int i = 0; i < 6 && !(lsb ? sv_l : sv_m); i++) begin
            @(posedge clock);
            #1;
        end
        while ((lsb ? sv_l : sv_m) && n < 40) begin
            bits = {bits[30:0], (lsb ? so_l : so_m)};
            rdy  = {rdy[30:0], (lsb ? rdy_l : rdy_m)};
            n++;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] bits, rdy;
        int          n, nv;

        // Reset held for two cycles
        @(posedge clock); @(posedge clock); #1;
        chk("rst_ready",  {31'd0, rdy_m},  32'd1);
        chk("rst_so",     {31'd0, so_m},   32'd0);
        chk("rst_valid",  {31'd0, sv_m},   32'd0);
        chk("rst_busy",   {31'd0, busy_m}, 32'd0);
        chk("rst_l_ready",{31'd0, rdy_l},  32'd1);
        @(negedge clock);
        rst = 1'b1;

        // Single word A5, MSB first
        offer_m(8'hA5);
        chk("a5_acc_ready", {31'd0, rdy_m},  32'd0);
        chk("a5_acc_busy",  {31'd0, busy_m}, 32'd1);
        chk("a5_acc_valid", {31'd0, sv_m},   32'd0);
        collect(1'b0, bits, rdy, n);
`ifdef PISO_PARITY_EN
        chk("a5_bits", bits, 32'h14A);
        chk("a5_len",  n,    32'd9);
`else
        chk("a5_bits", bits, 32'hA5);
        chk("a5_len",  n,    32'd8);
`endif
        chk("a5_idle_so",    {31'd0, so_m},   32'd0);
        chk("a5_idle_busy",  {31'd0, busy_m}, 32'd0);
        chk("a5_idle_ready", {31'd0, rdy_m},  32'd1);

        // Back-to-back F0, 0F
        fork
            begin
                offer_m(8'hF0);
                offer_m(8'h0F);
            end
            collect(1'b0, bits, rdy, n);
        join
`ifdef PISO_PARITY_EN
        chk("b2b_bits", bits, 32'h3C01E);
        chk("b2b_len",  n,    32'd18);
        chk("b2b_rdy",  rdy,  32'h201FF);
`else
        chk("b2b_bits", bits, 32'hF00F);
        chk("b2b_len",  n,    32'd16);
        chk("b2b_rdy",  rdy,  32'h80FF);
`endif
        chk("b2b_idle_busy", {31'd0, busy_m}, 32'd0);

        // LSB first, word 01
        @(negedge clock);
        din_l = 8'h01;
        dv_l  = 1'b1;
        @(posedge clock);
        #1;
        dv_l = 1'b0;
        collect(1'b1, bits, rdy, n);
`ifdef PISO_PARITY_EN
        chk("lsb_bits", bits, 32'h101);
        chk("lsb_len",  n,    32'd9);
`else
        chk("lsb_bits", bits, 32'h80);
        chk("lsb_len",  n,    32'd8);
`endif

        // Reset after the 3rd bit of FF with 55 held
        offer_m(8'hFF);
        @(negedge clock);
        din_m = 8'h55;
        dv_m  = 1'b1;
        @(posedge clock); #1;
        chk("mr_bit1", {30'd0, sv_m, so_m}, 32'd3);
        @(posedge clock); #1;
        dv_m = 1'b0;
        chk("mr_bit2", {30'd0, sv_m, so_m}, 32'd3);
        @(posedge clock); #1;
        chk("mr_bit3", {30'd0, sv_m, so_m}, 32'd3);
        chk("mr_held", {31'd0, rdy_m}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_valid", {31'd0, sv_m},   32'd0);
        chk("mr_ready", {31'd0, rdy_m},  32'd1);
        chk("mr_busy",  {31'd0, busy_m}, 32'd0);
        chk("mr_so",    {31'd0, so_m},   32'd0);
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clock); #1;
            if (sv_m) nv++;
        end
        chk("mr_no_bits", nv, 32'd0);

`ifdef PISO_PARITY_EN
        // Parity frame for 07
        offer_m(8'h07);
        collect(1'b0, bits, rdy, n);
        chk("par_bits", bits, 32'h00F);
        chk("par_len",  n,    32'd9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
